// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I word type and arbiter FSM state encoding
package rv32i_types;
   typedef logic [31:0] rv32i_word;
   typedef enum logic [1:0] {IDLE, SERVE, RESPOND} arb_state_t;
endpackage

// File: rtl/port_arbiter.sv
// rtl/port_arbiter.sv - two-port (instruction/data) arbiter onto a single physical memory port
module port_arbiter
   import rv32i_types::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        read_a,
   input  logic [31:0] address_a,
   output logic        resp_a,
   output logic [31:0] rdata_a,
   input  logic        read_b,
   input  logic        write,
   input  logic [3:0]  wmask,
   input  logic [31:0] address_b,
   input  logic [31:0] wdata,
   output logic        resp_b,
   output logic [31:0] rdata_b,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [31:0] pmem_address,
   output logic [31:0] pmem_wdata,
   output logic [3:0]  pmem_wmask,
   input  logic        pmem_resp,
   input  logic [31:0] pmem_rdata
);

   arb_state_t state, state_next;

   logic       last_grant;   // 1 = port B was granted last
   logic       grant_b;
   logic       op_write;
   rv32i_word  addr_q;
   rv32i_word  wdata_q;
   logic [3:0] wmask_q;
   rv32i_word  rdata_a_q;
   rv32i_word  rdata_b_q;

   logic pend_a, pend_b, pick_b, start;

   assign pend_a = read_a;
   assign pend_b = read_b | write;
   // On a tie, B wins only if A had the previous grant.
   assign pick_b = pend_b & (~pend_a | ~last_grant);
   assign start  = (state == IDLE) & (pend_a | pend_b);

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pend_a | pend_b) state_next = SERVE;
         SERVE:   if (pmem_resp)       state_next = RESPOND;
         RESPOND: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant <= 1'b1;
         grant_b    <= 1'b0;
         op_write   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
      end else begin
         if (start) begin
            grant_b    <= pick_b;
            last_grant <= pick_b;
            op_write   <= pick_b & write;
            addr_q     <= pick_b ? address_b : address_a;
            wdata_q    <= pick_b ? wdata : '0;
            wmask_q    <= (pick_b & write) ? wmask : 4'b0000;
         end
         if ((state == SERVE) && pmem_resp && !op_write) begin
            if (grant_b) rdata_b_q <= pmem_rdata;
            else         rdata_a_q <= pmem_rdata;
         end
      end
   end

   assign pmem_read    = (state == SERVE) & ~op_write;
   assign pmem_write   = (state == SERVE) &  op_write;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign pmem_wmask   = wmask_q;
   assign resp_a       = (state == RESPOND) & ~grant_b;
   assign resp_b       = (state == RESPOND) &  grant_b;
   assign rdata_a      = rdata_a_q;
   assign rdata_b      = rdata_b_q;

endmodule

// File: tb/tb_port_arbiter.sv
// tb/tb_port_arbiter.sv - directed table, corner sequences and randomized model check of port_arbiter
module tb_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        read_a = 1'b0, read_b = 1'b0, write = 1'b0;
   logic [31:0] address_a = '0, address_b = '0, wdata = '0;
   logic [3:0]  wmask = '0;
   logic        resp_a, resp_b, pmem_read, pmem_write;
   logic [31:0] rdata_a, rdata_b, pmem_address, pmem_wdata;
   logic [3:0]  pmem_wmask;
   logic        pmem_resp = 1'b0;
   logic [31:0] pmem_rdata = '0;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_rdata_a, m_rdata_b;

   port_arbiter dut (
      .clk(clk), .reset(reset),
      .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
      .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
      .wdata(wdata), .resp_b(resp_b), .rdata_b(rdata_b),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ra, rb, wr;
      logic [31:0] addr_a, addr_b, wd;
      logic [3:0]  wm;
      int          lat;
      logic [31:0] mem;
      logic        exp_b, exp_wr;
   } row_t;

   row_t rows[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      read_a = 0; read_b = 0; write = 0;
      address_a = '0; address_b = '0; wdata = '0; wmask = '0;
      pmem_resp = 0; pmem_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 0;
      clear_inputs();
      repeat (2) @(negedge clk);
      reset = 1;
      m_rdata_a = '0;
      m_rdata_b = '0;
   endtask

   task automatic do_txn(input row_t r, input string tag);
      int cnt;
      logic [31:0] exp_addr;
      exp_addr = r.exp_b ? r.addr_b : r.addr_a;
      @(negedge clk);
      read_a = r.ra; read_b = r.rb; write = r.wr;
      address_a = r.addr_a; address_b = r.addr_b; wdata = r.wd; wmask = r.wm;
      pmem_resp = 0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!(pmem_read | pmem_write) && cnt < 8);
      chk({tag, "_strobe_latency"}, cnt, 1);
      chk({tag, "_op"}, {pmem_read, pmem_write}, r.exp_wr ? 2'b01 : 2'b10);
      chk({tag, "_addr"}, pmem_address, exp_addr);
      chk({tag, "_wmask"}, pmem_wmask, r.exp_wr ? r.wm : 4'b0000);
      if (r.exp_wr) chk({tag, "_wdata"}, pmem_wdata, r.wd);
      for (int i = 0; i < r.lat; i++) begin
         @(negedge clk);
         chk({tag, "_hold"}, {pmem_read, pmem_write, pmem_address}, {r.exp_wr ? 2'b01 : 2'b10, exp_addr});
      end
      pmem_resp = 1; pmem_rdata = r.mem;
      @(negedge clk);
      pmem_resp = 0;
      chk({tag, "_resp"}, {resp_a, resp_b}, r.exp_b ? 2'b01 : 2'b10);
      chk({tag, "_strobe_off"}, {pmem_read, pmem_write}, 2'b00);
      if (!r.exp_wr) begin
         if (r.exp_b) m_rdata_b = r.mem;
         else         m_rdata_a = r.mem;
      end
      chk({tag, "_rdata_a"}, rdata_a, m_rdata_a);
      chk({tag, "_rdata_b"}, rdata_b, m_rdata_b);
      read_a = 0; read_b = 0; write = 0;
      @(negedge clk);
      chk({tag, "_resp_pulse"}, {resp_a, resp_b}, 2'b00);
   endtask

   // Randomized phase: transaction-level reference model.
   task automatic random_phase(input int ncyc);
      logic pa_prev = 0, pb_prev = 0, wr_prev = 0;
      logic [31:0] aa_prev = 0, ab_prev = 0, wd_prev = 0;
      logic [3:0] wm_prev = 0;
      bit idle_prev = 1, busy = 0, resp_due = 0, responded;
      bit exp_gb = 0, exp_wr = 0, last_b = 1, a_act = 0, b_act = 0;
      logic [31:0] exp_addr = 0, exp_wd = 0, mem_data = 0;
      logic [3:0] exp_wm = 0;
      int lat = 0;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         @(negedge clk);
         responded = 0;
         chk("rnd_exclusive", {resp_a & resp_b, pmem_read & pmem_write}, 2'b00);
         if (resp_due) begin
            chk("rnd_resp", {resp_a, resp_b}, exp_gb ? 2'b01 : 2'b10);
            chk("rnd_resp_strobe", {pmem_read, pmem_write}, 2'b00);
            if (!exp_wr) begin
               if (exp_gb) m_rdata_b = mem_data;
               else        m_rdata_a = mem_data;
            end
            if (exp_gb) b_act = 0; else a_act = 0;
            busy = 0; resp_due = 0; responded = 1;
         end else begin
            chk("rnd_noresp", {resp_a, resp_b}, 2'b00);
            if (idle_prev && (pa_prev | pb_prev)) begin
               exp_gb   = pb_prev & (!pa_prev | !last_b);
               last_b   = exp_gb;
               exp_wr   = exp_gb & wr_prev;
               exp_addr = exp_gb ? ab_prev : aa_prev;
               exp_wd   = wd_prev;
               exp_wm   = exp_wr ? wm_prev : 4'b0000;
               busy     = 1;
               lat      = $urandom_range(0, 3);
            end
            if (busy) begin
               chk("rnd_op", {pmem_read, pmem_write}, exp_wr ? 2'b01 : 2'b10);
               chk("rnd_addr", pmem_address, exp_addr);
               chk("rnd_wmask", pmem_wmask, exp_wm);
               if (exp_wr) chk("rnd_wdata", pmem_wdata, exp_wd);
            end else begin
               chk("rnd_idle_strobe", {pmem_read, pmem_write}, 2'b00);
            end
         end
         chk("rnd_rdata_a", rdata_a, m_rdata_a);
         chk("rnd_rdata_b", rdata_b, m_rdata_b);
         idle_prev = !busy && !responded;

         if (!a_act) begin
            address_a = $urandom;
            read_a = ($urandom_range(0, 3) == 0);
            a_act = read_a;
         end
         if (!b_act) begin
            int op;
            op = $urandom_range(0, 5);
            address_b = $urandom; wdata = $urandom; wmask = 4'($urandom);
            read_b = (op == 0 || op == 2);
            write  = (op == 1 || op == 2);
            b_act  = read_b | write;
         end
         pa_prev = read_a; pb_prev = read_b | write; wr_prev = write;
         aa_prev = address_a; ab_prev = address_b; wd_prev = wdata; wm_prev = wmask;

         pmem_rdata = $urandom;
         if (busy && !resp_due) begin
            if (lat == 0) begin
               pmem_resp = 1; mem_data = pmem_rdata; resp_due = 1;
            end else begin
               lat--; pmem_resp = 0;
            end
         end else begin
            pmem_resp = 1'($urandom_range(0, 1));
         end
      end
      clear_inputs();
   endtask

   initial begin
      int g[4];
      int n;
      row_t fresh;

      rows[0] = '{1'b1, 1'b0, 1'b0, 32'h60, 32'h0, 32'h0, 4'b0000, 3, 32'h0000_0013, 1'b0, 1'b0};
      rows[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'hDEAD_BEEF, 4'b0011, 1, 32'h1234_5678, 1'b1, 1'b1};
      rows[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 4'b1111, 0, 32'hCAFE_0001, 1'b1, 1'b0};
      rows[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'h1122_3344, 4'b1111, 2, 32'hFFFF_0000, 1'b1, 1'b1};
      rows[4] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 4'b0000, 1, 32'hA0A0_A0A0, 1'b0, 1'b0};
      rows[5] = '{1'b1, 1'b1, 1'b0, 32'h14, 32'h24, 32'h0, 4'b0000, 1, 32'hB0B0_B0B0, 1'b1, 1'b0};
      rows[6] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h44, 32'h0000_0055, 4'b1000, 0, 32'h0BAD_0BAD, 1'b1, 1'b1};

      clear_inputs();
      reset = 0;
      m_rdata_a = '0; m_rdata_b = '0;
      repeat (3) @(negedge clk);
      chk("reset_resp", {resp_a, resp_b}, 2'b00);
      chk("reset_strobes", {pmem_read, pmem_write}, 2'b00);
      chk("reset_rdata_a", rdata_a, 32'h0);
      chk("reset_rdata_b", rdata_b, 32'h0);
      chk("reset_pmem_addr", pmem_address, 32'h0);
      chk("reset_pmem_wdata", pmem_wdata, 32'h0);
      chk("reset_pmem_wmask", pmem_wmask, 4'b0000);
      reset = 1;

      for (int i = 0; i < 7; i++) do_txn(rows[i], $sformatf("row%0d", i));

      // pmem_resp stuck high: exactly one response
      @(negedge clk);
      read_b = 1; address_b = 32'h300; pmem_resp = 1; pmem_rdata = 32'h77;
      @(negedge clk);
      chk("stuck_strobe", {pmem_read, pmem_write, pmem_address}, {2'b10, 32'h300});
      @(negedge clk);
      chk("stuck_resp", {resp_a, resp_b}, 2'b01);
      chk("stuck_rdata_b", rdata_b, 32'h77);
      m_rdata_b = 32'h77;
      read_b = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("stuck_no_second", {resp_a, resp_b, pmem_read, pmem_write}, 4'b0000);
      end
      pmem_resp = 0;

      // reset in SERVE abandons the transaction
      @(negedge clk);
      read_a = 1; address_a = 32'h700;
      @(negedge clk);
      chk("rst_serve_strobe", {pmem_read, pmem_write}, 2'b10);
      reset = 0;
      @(negedge clk);
      chk("rst_serve_idle", {resp_a, resp_b, pmem_read, pmem_write}, 4'b0000);
      chk("rst_serve_rdata_b", rdata_b, 32'h0);
      reset = 1; read_a = 0;
      m_rdata_a = '0; m_rdata_b = '0;
      @(negedge clk);
      chk("rst_serve_noresp", {resp_a, resp_b, pmem_read, pmem_write}, 4'b0000);
      fresh = '{1'b1, 1'b0, 1'b0, 32'h704, 32'h0, 32'h0, 4'b0000, 1, 32'h5151_5151, 1'b0, 1'b0};
      do_txn(fresh, "after_rst");

      // both ports back-to-back from reset: strict alternation starting with A
      do_reset();
      read_a = 1; address_a = 32'h400; read_b = 1; address_b = 32'h500;
      pmem_resp = 1; pmem_rdata = 32'h99;
      n = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if ((resp_a | resp_b) && n < 4) begin
            g[n] = resp_b ? 1 : 0;
            n++;
         end
      end
      chk("alt_count", n, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("alt_grant%0d", i), (i < n) ? g[i] : -1, i % 2);
      clear_inputs();

      do_reset();
      random_phase(3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
